// File: rtl/andor_stim_checker.sv
// andor_stim_checker: clocked stimulus generator and response checker for a
// WIDTH-bit AND/OR block. Walks every {X,Y} operand pair, lets each vector
// settle for STIM_DELAY cycles, then compares the returned AND/OR results.
// Optional build macro: ANDOR_STOP_ON_ERR_EN (stop at the first mismatching
// vector and hold it on x_out/y_out/vec_idx).
module andor_stim_checker #(
    parameter int WIDTH      = 2,
    parameter int STIM_DELAY = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    input  logic [WIDTH-1:0]     and_in,
    input  logic [WIDTH-1:0]     or_in,
    output logic [2*WIDTH-1:0]   vec_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (STIM_DELAY > 1) ? $clog2(STIM_DELAY) : 1;
    localparam logic [CW-1:0] DCNT_LAST = CW'(STIM_DELAY - 1);
    localparam logic [IW-1:0] VEC_LAST  = '1;
    localparam logic [IW:0]   ERR_MAX   = '1;

`ifdef ANDOR_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [IW-1:0]    vec_reg,   vec_next;
    logic [CW-1:0]    dcnt_reg,  dcnt_next;
    logic [IW:0]      err_reg,   err_next;

    logic [WIDTH-1:0] x_cur;
    logic [WIDTH-1:0] y_cur;
    logic [WIDTH-1:0] bit_mismatch;
    logic             mismatch;

    // Operands are fixed slices of the vector index, so they change on the
    // same edge as vec_idx.
    assign x_cur = vec_reg[IW-1:WIDTH];
    assign y_cur = vec_reg[WIDTH-1:0];

    // Per-bit comparison of the returned results against the expected ones.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
            assign bit_mismatch[gi] = (and_in[gi] != (x_cur[gi] & y_cur[gi])) |
                                      (or_in[gi]  != (x_cur[gi] | y_cur[gi]));
        end
    endgenerate

    assign mismatch = |bit_mismatch;

    // State and datapath registers; reset returns everything to IDLE/zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            dcnt_reg  <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            dcnt_reg  <= dcnt_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: sequence vectors, wait the settle time, check results.
    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        dcnt_next  = dcnt_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    vec_next   = '0;
                    dcnt_next  = '0;
                    err_next   = '0;
                    state_next = DRIVE;
                end
            end

            DRIVE: begin
                if (dcnt_reg == DCNT_LAST) begin
                    state_next = CHECK;
                end else begin
                    dcnt_next = dcnt_reg + 1'b1;
                end
            end

            CHECK: begin
                if (mismatch && (err_reg != ERR_MAX)) begin
                    err_next = err_reg + 1'b1;
                end
                if (STOP_ON_ERR && mismatch) begin
                    // Hold the failing vector on the outputs.
                    state_next = DONE;
                end else if (vec_reg == VEC_LAST) begin
                    state_next = DONE;
                end else begin
                    vec_next   = vec_reg + 1'b1;
                    dcnt_next  = '0;
                    state_next = DRIVE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign x_out     = x_cur;
    assign y_out     = y_cur;
    assign vec_idx   = vec_reg;
    assign err_count = err_reg;
    assign busy      = (state_reg == DRIVE) || (state_reg == CHECK);
    assign done      = (state_reg == DONE);
    assign pass      = (state_reg == DONE) && (err_reg == '0);

endmodule

// File: tb/tb_andor_stim_checker.sv
// tb_andor_stim_checker: drives andor_stim_checker against a behavioural
// AND/OR block with selectable faults. A run table covers the fault modes;
// hand-written sequences cover mid-run reset, start while busy and restart.
module tb_andor_stim_checker;

    localparam int WIDTH = 2;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] x_out, y_out, and_in, or_in;
    logic [3:0] vec_idx;
    logic       busy, done, pass;
    logic [4:0] err_count;

    // 0: correct block, 1: or_in bit0 stuck at 0, 2: and_in forced to 2'b11
    int mode = 0;
    int cyc  = 0;
    int t0   = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    andor_stim_checker #(.WIDTH(WIDTH), .STIM_DELAY(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x_out     (x_out),
        .y_out     (y_out),
        .and_in    (and_in),
        .or_in     (or_in),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    // Behavioural AND/OR block with optional fault injection.
    always_comb begin
        and_in = x_out & y_out;
        or_in  = x_out | y_out;
        if (mode == 1) or_in[0] = 1'b0;
        if (mode == 2) and_in = 2'b11;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard of expected {vec_idx, x, y} per visited vector.
    typedef struct packed {
        logic [3:0] idx;
        logic [1:0] x;
        logic [1:0] y;
    } vec_t;

    vec_t       sb_q[$];
    logic       prev_busy = 1'b0;
    logic [3:0] prev_idx  = 4'd0;

    // Pop and compare one entry each time a new vector is presented.
    always @(negedge clk) begin
        if (busy === 1'b1 && (prev_busy !== 1'b1 || vec_idx !== prev_idx)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_vector: got unexpected vector %0d, expected none", vec_idx);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check("sb_vector", {vec_idx, x_out, y_out}, e);
            end
        end
        prev_busy <= busy;
        prev_idx  <= vec_idx;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, pass, err_count, vec_idx, x_out, y_out}, 32'd0);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic start_run();
        for (int i = 0; i < 16; i++) begin
            vec_t e;
            e.idx = i[3:0];
            e.x   = i[3:2];
            e.y   = i[1:0];
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        check("not_busy_before_start", busy, 1'b0);
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        check("busy_after_start", {busy, done}, 2'b10);
    endtask

    task automatic wait_done(output int elapsed);
        while (done !== 1'b1 && (cyc - t0) < LIMIT) begin
            @(posedge clk);
            #1;
        end
        elapsed = cyc - t0;
    endtask

    task automatic wait_vec(input logic [3:0] k);
        while (vec_idx !== k && (cyc - t0) < LIMIT) begin
            @(posedge clk);
            #1;
        end
        check("reach_vec", vec_idx, k);
    endtask

    task automatic finish_run(input int nvis);
        check("sb_leftover", sb_q.size(), 16 - nvis);
        sb_q.delete();
    endtask

    typedef struct {
        int         mode;
        int         err;
        logic       pass;
        int         cycles;
        logic [1:0] x;
        logic [1:0] y;
        int         nvis;
    } row_t;

    row_t rows[3];

    initial begin
        int el;
        int busy_mode;
        int busy_err;

`ifdef ANDOR_STOP_ON_ERR_EN
        rows[0] = '{mode: 0, err: 0,  pass: 1'b1, cycles: 336, x: 2'b11, y: 2'b11, nvis: 16};
        rows[1] = '{mode: 1, err: 1,  pass: 1'b0, cycles: 42,  x: 2'b00, y: 2'b01, nvis: 2};
        rows[2] = '{mode: 2, err: 1,  pass: 1'b0, cycles: 21,  x: 2'b00, y: 2'b00, nvis: 1};
        busy_mode = 0;
        busy_err  = 0;
`else
        rows[0] = '{mode: 0, err: 0,  pass: 1'b1, cycles: 336, x: 2'b11, y: 2'b11, nvis: 16};
        rows[1] = '{mode: 1, err: 12, pass: 1'b0, cycles: 336, x: 2'b11, y: 2'b11, nvis: 16};
        rows[2] = '{mode: 2, err: 15, pass: 1'b0, cycles: 336, x: 2'b11, y: 2'b11, nvis: 16};
        busy_mode = 1;
        busy_err  = 12;
`endif

        reset = 1'b1;
        start = 1'b0;

        // Table-driven full runs, one per fault mode.
        for (int r = 0; r < 3; r++) begin
            mode = rows[r].mode;
            do_reset();
            repeat (3) @(negedge clk);
            start_run();
            wait_done(el);
            check("done_cycles", el, rows[r].cycles);
            check("err_count", err_count, rows[r].err);
            check("pass", pass, rows[r].pass);
            check("done_not_busy", {busy, done}, 2'b01);
            check("final_xy", {x_out, y_out}, {rows[r].x, rows[r].y});
            finish_run(rows[r].nvis);
            $display("run %0d mode %0d: cycles=%0d err=%0d pass=%0b", r, mode, el, err_count, pass);
        end

        // Reset in DRIVE at vector 7, then a clean full run.
        mode = 0;
        do_reset();
        start_run();
        wait_vec(4'd7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset", {busy, done, pass, err_count, vec_idx, x_out, y_out}, 32'd0);
        reset = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        start_run();
        wait_done(el);
        check("post_reset_cycles", el, 336);
        check("post_reset_pass", {pass, err_count}, 6'b1_00000);
        finish_run(16);
        $display("run mid-reset: cycles=%0d err=%0d pass=%0b", el, err_count, pass);

        // start pulsed at vector 3 while busy must be ignored.
        mode = busy_mode;
        do_reset();
        start_run();
        wait_vec(4'd3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_ignored", vec_idx, 4'd3);
        wait_done(el);
        check("busy_start_cycles", el, 336);
        check("busy_start_err", err_count, busy_err);
        finish_run(16);
        $display("run start-while-busy: cycles=%0d err=%0d pass=%0b", el, err_count, pass);

        // Restart from DONE with the correct block: errors clear.
        mode = 0;
        repeat (4) @(negedge clk);
        check("done_holds_err", {done, err_count}, {1'b1, 5'(busy_err)});
        start_run();
        check("restart_clears", {err_count, done, pass}, 7'd0);
        wait_done(el);
        check("restart_cycles", el, 336);
        check("restart_pass", {pass, err_count}, 6'b1_00000);
        finish_run(16);
        $display("run restart: cycles=%0d err=%0d pass=%0b", el, err_count, pass);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
